// File: rtl/flash_rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// flash_rom_loader_pkg
// Shared definitions for the SPI-flash boot loader:
//   - state_t            : loader FSM states (WAKE/WAKE_GAP exist only when
//                          FLASH_WAKEUP_EN is defined)
//   - OP_READ / OP_WAKE  : SPI flash opcodes (read data, release power-down)
//   - WAKE_GAP_CYCLES    : clk cycles chip select stays high after the wake
//                          opcode before the read command may start
//   - read_cmd()         : builds the 32-bit read frame (opcode + 24-bit addr)
// Configuration macro: FLASH_WAKEUP_EN
// -----------------------------------------------------------------------------
package flash_rom_loader_pkg;

  typedef enum logic [2:0] {
    BOOT,
`ifdef FLASH_WAKEUP_EN
    WAKE,
    WAKE_GAP,
`endif
    CMD,
    DATA,
    DONE
  } state_t;

  localparam logic [7:0] OP_READ         = 8'h03;
  localparam logic [7:0] OP_WAKE         = 8'hAB;
  localparam int         WAKE_GAP_CYCLES = 64;

  function automatic logic [31:0] read_cmd(input logic [23:0] offset);
    return {OP_READ, offset};
  endfunction

endpackage

// File: rtl/flash_rom_loader_spi_shift_master.sv
// -----------------------------------------------------------------------------
// spi_shift_master
// SPI mode-0 master: SCLK divider plus a 32-bit MSB-first shift engine.
//   clk, reset   : system clock, synchronous active-high reset
//   start        : load tx_data/nbits and begin a transfer (may be asserted
//                  in the same cycle as done to chain transfers gap-free)
//   nbits        : bits in this transfer, 1..32 (taken from tx_data[31:...])
//   tx_data      : transmit word, MSB first
//   miso         : serial data in, sampled on the clk edge that raises sclk
//   done         : combinational, high in the last cycle of a transfer; the
//                  following edge produces the final falling sclk
//   rx_data      : received bits, most recent bit in rx_data[0]
//   sclk, mosi   : SPI clock (idles low) and data out (changes on fall)
// Each sclk half-period lasts SCLK_DIV clk cycles.
// -----------------------------------------------------------------------------
module spi_shift_master #(
  parameter int SCLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  nbits,
  input  logic [31:0] tx_data,
  input  logic        miso,
  output logic        done,
  output logic [31:0] rx_data,
  output logic        sclk,
  output logic        mosi
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic             busy;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [5:0]       nbits_q;
  logic [31:0]      tx_q;
  logic             tick;

  // A half-period ends on this cycle's edge.
  assign tick = busy && (div_cnt == DIV_W'(SCLK_DIV - 1));
  // Last bit's high phase is ending: rx_data already holds every bit.
  assign done = tick && sclk && (bit_cnt == nbits_q - 6'd1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      nbits_q <= '0;
      tx_q    <= '0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (start) begin
      // Restarting here also produces the falling edge of a chained transfer,
      // so consecutive transfers keep a uniform SCLK period.
      busy    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      nbits_q <= nbits;
      sclk    <= 1'b0;
      mosi    <= tx_data[31];
      tx_q    <= {tx_data[30:0], 1'b0};
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
      if (!sclk) begin
        rx_data <= {rx_data[30:0], miso};
      end else begin
        bit_cnt <= bit_cnt + 6'd1;
        mosi    <= done ? 1'b0 : tx_q[31];
        tx_q    <= {tx_q[30:0], 1'b0};
        if (done) busy <= 1'b0;
      end
    end else if (busy) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/flash_rom_loader.sv
// -----------------------------------------------------------------------------
// flash_rom_loader
// Copies a DEPTH x WORD_WIDTH image from SPI flash (starting at byte address
// FLASH_OFFSET) into an on-chip ROM, then serves registered CPU fetches.
//   clk, reset    : system clock, synchronous active-high reset
//   reload        : one-cycle pulse; restarts the load when idle in DONE
//   ready         : full image resident
//   words_loaded  : words written during the current load
//   address       : CPU fetch address (>= DEPTH reads as 0)
//   instruction   : fetch data, one cycle after address; 0 while !ready
//   spi_cs/sclk/mosi/miso : SPI flash port, mode 0, cs active low
// Configuration macro: FLASH_WAKEUP_EN -- when defined, the first load after
// reset sends the release-power-down opcode and waits WAKE_GAP_CYCLES first.
// WORD_WIDTH must not exceed 32 (one shift-engine transfer per word).
// -----------------------------------------------------------------------------
module flash_rom_loader
  import flash_rom_loader_pkg::*;
#(
  parameter int          WORD_WIDTH   = 16,
  parameter int          DEPTH        = 4096,
  parameter logic [23:0] FLASH_OFFSET = 24'h100000,
  parameter int          SCLK_DIV     = 2,
  localparam int         ADDR_BITS    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload,
  output logic                  ready,
  output logic [ADDR_BITS:0]    words_loaded,
  input  logic [15:0]           address,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  spi_cs,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int         CNT_BITS  = ADDR_BITS + 1;
  localparam logic [5:0] WORD_BITS = 6'(WORD_WIDTH);

  state_t      state_q, state_d;
  logic        start;
  logic        done;
  logic [5:0]  nbits;
  logic [31:0] tx_data;
  logic [31:0] rx_data;
  logic        rom_we;
  logic        clr_count;
  logic        cs_low_d;
  logic        last_word;
  logic        in_range;
  logic        unused_rx;

  logic [WORD_WIDTH-1:0] rom [DEPTH];

`ifdef FLASH_WAKEUP_EN
  logic [6:0] gap_cnt;
`endif

  assign last_word = (words_loaded == CNT_BITS'(DEPTH - 1));
  assign in_range  = ({16'h0, address} < 32'(DEPTH));
  // Only the low WORD_WIDTH bits of the receive register hold the word.
  assign unused_rx = ^rx_data;

  spi_shift_master #(
    .SCLK_DIV (SCLK_DIV)
  ) u_spi (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .nbits   (nbits),
    .tx_data (tx_data),
    .miso    (spi_miso),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi)
  );

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    nbits     = 6'd32;
    tx_data   = read_cmd(FLASH_OFFSET);
    rom_we    = 1'b0;
    clr_count = 1'b0;
    case (state_q)
      BOOT: begin
`ifdef FLASH_WAKEUP_EN
        state_d = WAKE;
        start   = 1'b1;
        nbits   = 6'd8;
        tx_data = {OP_WAKE, 24'h0};
`else
        state_d = CMD;
        start   = 1'b1;
`endif
      end
`ifdef FLASH_WAKEUP_EN
      WAKE: begin
        if (done) state_d = WAKE_GAP;
      end
      WAKE_GAP: begin
        if (gap_cnt == 7'(WAKE_GAP_CYCLES - 1)) begin
          state_d = CMD;
          start   = 1'b1;
        end
      end
`endif
      CMD: begin
        // Chain straight into the first data word; cs stays low.
        if (done) begin
          state_d = DATA;
          start   = 1'b1;
          nbits   = WORD_BITS;
          tx_data = '0;
        end
      end
      DATA: begin
        if (done) begin
          rom_we = 1'b1;
          if (last_word) begin
            state_d = DONE;
          end else begin
            start   = 1'b1;
            nbits   = WORD_BITS;
            tx_data = '0;
          end
        end
      end
      DONE: begin
        if (reload) begin
          state_d   = CMD;
          start     = 1'b1;
          clr_count = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase

    cs_low_d = (state_d == CMD) || (state_d == DATA);
`ifdef FLASH_WAKEUP_EN
    if (state_d == WAKE) cs_low_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      spi_cs       <= 1'b1;
      ready        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q <= state_d;
      spi_cs  <= ~cs_low_d;
      ready   <= (state_d == DONE);
      if (clr_count)   words_loaded <= '0;
      else if (rom_we) words_loaded <= words_loaded + CNT_BITS'(1);
    end
  end

`ifdef FLASH_WAKEUP_EN
  always_ff @(posedge clk) begin
    if (reset || state_q != WAKE_GAP) gap_cnt <= '0;
    else                              gap_cnt <= gap_cnt + 7'd1;
  end
`endif

  // NOTE: the ROM array has no reset branch so it maps onto block RAM; its
  // contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rom_we) rom[words_loaded[ADDR_BITS-1:0]] <= rx_data[WORD_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset || !ready || !in_range) instruction <= '0;
    else                              instruction <= rom[address[ADDR_BITS-1:0]];
  end

endmodule

// File: tb/tb_flash_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_flash_rom_loader
// Directed/randomized bench for flash_rom_loader (DEPTH=16, WORD_WIDTH=16,
// SCLK_DIV=3). A behavioural SPI flash model serves a word image from byte
// address 0x100000 and records every chip-select frame; fetched words are
// compared against the same image array.
// -----------------------------------------------------------------------------
module tb_flash_rom_loader;

  localparam int          WORD_WIDTH = 16;
  localparam int          DEPTH      = 16;
  localparam int          SCLK_DIV   = 3;
  localparam int          ADDR_BITS  = 4;
  localparam logic [23:0] OFFSET     = 24'h100000;
  localparam int          LOAD_BITS  = 32 + DEPTH * WORD_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  reload = 1'b0;
  logic [15:0]           address = 16'h0;
  logic                  spi_miso = 1'b0;
  logic                  ready;
  logic [ADDR_BITS:0]    words_loaded;
  logic [WORD_WIDTH-1:0] instruction;
  logic                  spi_cs, spi_sclk, spi_mosi;

  always #5 clk = ~clk;

  flash_rom_loader #(
    .WORD_WIDTH   (WORD_WIDTH),
    .DEPTH        (DEPTH),
    .FLASH_OFFSET (OFFSET),
    .SCLK_DIV     (SCLK_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .reload       (reload),
    .ready        (ready),
    .words_loaded (words_loaded),
    .address      (address),
    .instruction  (instruction),
    .spi_cs       (spi_cs),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- flash model ----------------
  logic [15:0] img [DEPTH];

  typedef struct {
    logic [31:0] cmd;
    int          bits;
    int          gap;
  } frame_t;
  frame_t frames[$];

  int          bit_idx = 0;
  logic [31:0] cmd_sh = 32'h0;
  int          cs_high_cnt = 0;
  int          frame_gap = 0;
  int          sclk_run = 0;
  logic        sclk_prev = 1'b0;
  int          sclk_bad = 0;

  function automatic logic flash_bit(input logic [23:0] base, input int k);
    int b, w;
    logic [7:0] byt;
    b = int'(base) - int'(OFFSET) + k / 8;
    w = b / 2;
    if (b < 0 || w >= DEPTH) byt = 8'hFF;
    else if ((b % 2) == 1)   byt = img[w][7:0];
    else                     byt = img[w][15:8];
    return byt[7 - (k % 8)];
  endfunction

  always @(negedge spi_cs) begin
    bit_idx   = 0;
    cmd_sh    = 32'h0;
    spi_miso  = 1'b0;
    frame_gap = cs_high_cnt;
  end

  always @(posedge spi_cs) begin
    if (bit_idx > 0) frames.push_back('{cmd_sh, bit_idx, frame_gap});
    cs_high_cnt = 0;
  end

  always @(posedge spi_sclk) begin
    if (!spi_cs) begin
      if (bit_idx < 32) cmd_sh = {cmd_sh[30:0], spi_mosi};
      bit_idx++;
    end
  end

  always @(negedge spi_sclk) begin
    if (!spi_cs && bit_idx >= 32 && cmd_sh[31:24] == 8'h03)
      spi_miso = flash_bit(cmd_sh[23:0], bit_idx - 32);
  end

  // SCLK half-period monitor and cs-high duration counter.
  always @(negedge clk) begin
    if (spi_cs) begin
      cs_high_cnt++;
      sclk_run  = 0;
      sclk_prev = 1'b0;
    end else if (spi_sclk == sclk_prev) begin
      sclk_run++;
    end else begin
      if (sclk_run != SCLK_DIV) sclk_bad++;
      sclk_run  = 1;
      sclk_prev = spi_sclk;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ready), 32'd1);
  endtask

  task automatic wait_count(input int target, input string tag);
    int n;
    n = 0;
    while (int'(words_loaded) != target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(words_loaded), 32'(target));
  endtask

  task automatic fetch_check(input logic [15:0] a, input string tag);
    logic        r;
    logic [15:0] exp;
    address = a;
    r       = ready;
    @(negedge clk);
    exp = (r && a < 16'(DEPTH)) ? img[a[ADDR_BITS-1:0]] : 16'h0;
    check(tag, 32'(instruction), 32'(exp));
  endtask

  task automatic new_image();
    for (int i = 0; i < DEPTH; i++) img[i] = 16'($urandom);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_read_frame(input string tag);
    check({tag, "_cmd"},  frames[$].cmd, {8'h03, OFFSET});
    check({tag, "_bits"}, 32'(frames[$].bits), 32'(LOAD_BITS));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    new_image();
    img[0] = 16'h1234;
    img[1] = 16'hABCD;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_cs",    32'(spi_cs), 32'd1);
    check("rst_sclk",  32'(spi_sclk), 32'd0);
    check("rst_mosi",  32'(spi_mosi), 32'd0);
    check("rst_count", 32'(words_loaded), 32'd0);
    check("rst_instr", 32'(instruction), 32'd0);
    reset = 1'b0;

    // Load 1: fetch during load reads zero.
    repeat (100) @(negedge clk);
    check("loading_ready", 32'(ready), 32'd0);
    fetch_check(16'd1, "fetch_not_ready");
    wait_ready("load1_ready");
    check("load1_count", 32'(words_loaded), 32'(DEPTH));
`ifdef FLASH_WAKEUP_EN
    check("wake_frames", 32'(frames.size()), 32'd2);
    check("wake_bits",   32'(frames[0].bits), 32'd8);
    check("wake_opcode", 32'(frames[0].cmd[7:0]), 32'hAB);
    check("wake_gap",    32'(frames[1].gap >= 64), 32'd1);
`else
    check("boot_frames", 32'(frames.size()), 32'd1);
`endif
    check_read_frame("load1");

    fetch_check(16'd1, "fetch_addr1");
    check("fetch_abcd", 32'(instruction), 32'h0000ABCD);
    fetch_check(16'd0, "fetch_addr0");
    for (int i = 0; i < 20; i++) fetch_check(16'($urandom_range(0, 31)), "fetch_rand");
    fetch_check(16'd16, "fetch_oob16");
    fetch_check(16'hFFFF, "fetch_oobmax");
    check("sclk_period1", 32'(sclk_bad), 32'd0);

    // Load 2: reload, then reset at words_loaded = 5, load restarts.
    new_image();
    pulse_reload();
    check("reload_ready_low", 32'(ready), 32'd0);
    check("reload_count_clr", 32'(words_loaded), 32'd0);
    wait_count(5, "reach_5");
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cs",    32'(spi_cs), 32'd1);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_sclk",  32'(spi_sclk), 32'd0);
    check("midrst_count", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    wait_ready("load2_ready");
    check_read_frame("load2");
    for (int i = 0; i < DEPTH; i++) fetch_check(16'(i), "fetch_load2");

    // Load 3: reload with no wake frame; a reload mid-DATA is ignored.
    new_image();
    frames.delete();
    pulse_reload();
    check("reload2_ready_low", 32'(ready), 32'd0);
    wait_count(8, "reach_8");
    pulse_reload();
    check("ignored_count", 32'(words_loaded), 32'd8);
    wait_ready("load3_ready");
    check("reload_frames", 32'(frames.size()), 32'd1);
    check_read_frame("load3");
    for (int i = 0; i < DEPTH; i++) fetch_check(16'(i), "fetch_load3");
    check("sclk_period_all", 32'(sclk_bad), 32'd0);

    // Reload coincident with reset: reset wins.
    reload = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("rr_ready", 32'(ready), 32'd0);
    check("rr_cs",    32'(spi_cs), 32'd1);
    check("rr_count", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
